// File: rtl/rs_encode_resp_framer.sv
`default_nettype none
// ============================================================================
// Module   : rs_encode_resp_framer
// Brief    : Store-and-forward framer behind the RS stream encoder. Buffers
//            one encoder response and emits a header line (stored line count,
//            block count, overflow bit) ahead of the buffered payload.
// Revision : 1.0 - initial release
// ============================================================================
module rs_encode_resp_framer #(
    parameter int DATA_W           = 512,
    parameter int NUM_REQ_BLOCKS_W = 8,
    parameter int BUF_LINES        = 256,
    parameter int BUF_LINES_W      = $clog2(BUF_LINES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        src_framer_meta_val,
    input  logic [NUM_REQ_BLOCKS_W-1:0] src_framer_meta_num_blocks,
    output logic                        framer_src_meta_rdy,
    input  logic                        encoder_framer_data_val,
    input  logic [DATA_W-1:0]           encoder_framer_data,
    input  logic                        encoder_framer_data_last,
    output logic                        framer_encoder_data_rdy,
    output logic                        framer_dst_data_val,
    output logic [DATA_W-1:0]           framer_dst_data,
    output logic                        framer_dst_data_last,
    input  logic                        dst_framer_data_rdy,
    output logic                        framer_overflow
);

    typedef enum logic [1:0] {
        ST_WAIT_META = 2'd0,
        ST_FILL      = 2'd1,
        ST_HDR       = 2'd2,
        ST_DRAIN     = 2'd3
    } state_t;

    // Counters carry one extra bit so a completely full buffer is representable.
    localparam logic [BUF_LINES_W:0] C_BUF_LINES = (BUF_LINES_W + 1)'(BUF_LINES);
    localparam logic [BUF_LINES_W:0] C_CNT_ONE   = (BUF_LINES_W + 1)'(1);

    state_t                      state_q;
    logic [NUM_REQ_BLOCKS_W-1:0] num_blocks_q;
    logic [BUF_LINES_W:0]        wr_cnt_q;
    logic [BUF_LINES_W:0]        rd_cnt_q;
    logic                        req_ovf_q;
    logic                        overflow_q;
    logic                        meta_rdy_q;
    logic                        enc_rdy_q;
    logic                        out_val_q;
    logic [DATA_W-1:0]           out_data_q;
    logic                        out_last_q;

    // Payload storage and its registered read port.
    logic [DATA_W-1:0]           mem_q [BUF_LINES];
    logic [DATA_W-1:0]           rd_data_q;

    logic                        w_meta_fire;
    logic                        w_enc_fire;
    logic                        w_full;
    logic                        w_we;
    logic                        w_discard;
    logic [BUF_LINES_W:0]        w_wr_cnt_d;
    logic                        w_req_ovf_d;
    logic [DATA_W-1:0]           w_hdr;
    logic                        w_out_fire;
    logic                        w_load;
    logic [BUF_LINES_W:0]        w_rd_cnt_d;

    // Handshake qualifiers and buffer-write decision for the current line.
    always_comb begin
        w_meta_fire = src_framer_meta_val & meta_rdy_q;
        w_enc_fire  = encoder_framer_data_val & enc_rdy_q;
        w_full      = (wr_cnt_q == C_BUF_LINES);
        w_we        = w_enc_fire & ~w_full;
        w_discard   = w_enc_fire & w_full;
        w_wr_cnt_d  = w_we ? (wr_cnt_q + C_CNT_ONE) : wr_cnt_q;
        w_req_ovf_d = req_ovf_q | w_discard;
        w_out_fire  = out_val_q & dst_framer_data_rdy;
    end

    // Header is built from the post-update count so the line accepted
    // together with last is already reflected in it.
    always_comb begin
        w_hdr        = '0;
        w_hdr[15:0]  = 16'(w_wr_cnt_d);
        w_hdr[31:16] = 16'(num_blocks_q);
        w_hdr[32]    = w_req_ovf_d;
    end

    // Drain read pointer: the output register refills whenever it is empty or
    // being consumed. The memory address is the next pointer value, so
    // rd_data_q always holds mem[rd_cnt_q] while draining.
    always_comb begin
        w_load     = (state_q == ST_DRAIN) & (~out_val_q | dst_framer_data_rdy)
                   & (rd_cnt_q != wr_cnt_q);
        w_rd_cnt_d = '0;
        if (state_q == ST_DRAIN) begin
            w_rd_cnt_d = w_load ? (rd_cnt_q + C_CNT_ONE) : rd_cnt_q;
        end
    end

    // Payload buffer: write during FILL, synchronous read every cycle.
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem_q[wr_cnt_q[BUF_LINES_W-1:0]] <= encoder_framer_data;
        end
        rd_data_q <= mem_q[w_rd_cnt_d[BUF_LINES_W-1:0]];
    end

    // Framer control FSM with registered handshake and output signals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_WAIT_META;
            num_blocks_q <= '0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            req_ovf_q    <= 1'b0;
            overflow_q   <= 1'b0;
            meta_rdy_q   <= 1'b0;
            enc_rdy_q    <= 1'b0;
            out_val_q    <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
        end else begin
            rd_cnt_q <= w_rd_cnt_d;
            if (w_discard) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                ST_WAIT_META: begin
                    meta_rdy_q <= 1'b1;
                    if (w_meta_fire) begin
                        meta_rdy_q   <= 1'b0;
                        num_blocks_q <= src_framer_meta_num_blocks;
                        wr_cnt_q     <= '0;
                        req_ovf_q    <= 1'b0;
                        enc_rdy_q    <= 1'b1;
                        state_q      <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_enc_fire) begin
                        wr_cnt_q  <= w_wr_cnt_d;
                        req_ovf_q <= w_req_ovf_d;
                        if (encoder_framer_data_last) begin
                            enc_rdy_q  <= 1'b0;
                            out_val_q  <= 1'b1;
                            out_data_q <= w_hdr;
                            out_last_q <= 1'b0;
                            state_q    <= ST_HDR;
                        end
                    end
                end
                ST_HDR: begin
                    if (w_out_fire) begin
                        out_val_q <= 1'b0;
                        state_q   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_load) begin
                        out_val_q  <= 1'b1;
                        out_data_q <= rd_data_q;
                        out_last_q <= (rd_cnt_q == (wr_cnt_q - C_CNT_ONE));
                    end else if (w_out_fire) begin
                        out_val_q  <= 1'b0;
                        out_last_q <= 1'b0;
                        if (out_last_q) begin
                            meta_rdy_q <= 1'b1;
                            state_q    <= ST_WAIT_META;
                        end
                    end
                end
                default: begin
                    state_q <= ST_WAIT_META;
                end
            endcase
        end
    end

    assign framer_src_meta_rdy     = meta_rdy_q;
    assign framer_encoder_data_rdy = enc_rdy_q;
    assign framer_dst_data_val     = out_val_q;
    assign framer_dst_data         = out_data_q;
    assign framer_dst_data_last    = out_last_q;
    assign framer_overflow         = overflow_q;

endmodule
`default_nettype wire

// File: doc/rs_encode_resp_framer.md
Name: rs_encode_resp_framer

Overview:
- Store-and-forward framer directly downstream of the RS stream encoder.
- Consumes the encoder response stream (data lines of every block, then parity lines, with last on the final line) plus a per-request metadata beat carrying the block count.
- Emits one header line, then the buffered payload, so the consumer (network/storage TX) knows the frame length before the payload arrives.
- Handles one request at a time.

Parameters:
DATA_W, 512, line width in bits; must be >= 64
NUM_REQ_BLOCKS_W, 8, width of block-count field
BUF_LINES, 256, payload buffer depth in lines; power of 2
BUF_LINES_W, $clog2(BUF_LINES), buffer address width

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
src_framer_meta_val  in  1  metadata valid
src_framer_meta_num_blocks  in  NUM_REQ_BLOCKS_W  block count of the request
framer_src_meta_rdy  out  1  metadata ready
encoder_framer_data_val  in  1  encoder line valid
encoder_framer_data  in  DATA_W  encoder line
encoder_framer_data_last  in  1  final line of the response
framer_encoder_data_rdy  out  1  encoder line ready
framer_dst_data_val  out  1  output line valid
framer_dst_data  out  DATA_W  output line (header or payload)
framer_dst_data_last  out  1  final output line
dst_framer_data_rdy  in  1  output ready
framer_overflow  out  1  sticky overflow flag; cleared by reset only

Behaviour:
- Handshake: a transfer occurs when val && rdy on the same clk edge. Once val is asserted, data, last and val are held stable until rdy.
- Reset (async assert, sync-deassert domain assumed upstream): state=WAIT_META; counters=0; framer_overflow=0. All rdy/val outputs are 0, and framer_dst_data and last are 0.
- State WAIT_META:
  - framer_src_meta_rdy=1; framer_encoder_data_rdy=0.
  - On meta handshake: latch num_blocks, clear wr_cnt (BUF_LINES_W+1 bits) and the req_ovf bit, go to FILL.
- State FILL:
  - framer_encoder_data_rdy=1.
  - Each accepted line with wr_cnt < BUF_LINES is written to buf[wr_cnt], then wr_cnt++.
  - Each accepted line with wr_cnt == BUF_LINES is discarded, and req_ovf and framer_overflow are set.
  - On an accepted line with last=1, go to HDR the next cycle. This applies to the line's write/discard in the same cycle.
- State HDR:
  - framer_dst_data_val=1.
  - Header line: bits[15:0]=wr_cnt zero-extended (payload lines stored), bits[31:16]=num_blocks zero-extended, bit[32]=req_ovf, all other bits 0.
  - last=0, except when wr_cnt==0 is impossible (FILL always stores >= 1 line unless overflow with BUF_LINES... never 0). Header last is therefore always 0.
  - On handshake: rd_cnt=0, go to DRAIN.
- State DRAIN:
  - Outputs buf[rd_cnt]. The memory read is registered, so a 1-entry prefetch/output register is required.
  - framer_dst_data_val is deasserted for at most one cycle after entering DRAIN, with no bubbles between consecutive lines while rdy is held high.
  - framer_dst_data_last=1 exactly on the line with rd_cnt==wr_cnt-1.
  - On the last handshake go to WAIT_META. A new meta beat is accepted no earlier than the following cycle.
- Throughput: one line per cycle in FILL and in DRAIN.
- Added latency: from the last input line accepted (cycle T), the header is valid at T+1, and payload line 0 is valid no later than T+3 with rdy high.
- Back-pressure: dst rdy low stalls HDR/DRAIN indefinitely with outputs stable. Encoder lines are never accepted outside FILL.
- Boundaries:
  - Exactly BUF_LINES lines: no overflow, header count=BUF_LINES.
  - Line BUF_LINES+1: overflow, and the header count stays BUF_LINES.
  - Single-line response with last on the first line: header count=1, and that line carries last.
  - Encoder val before meta: not accepted, since rdy=0.
- Reset mid-operation: buffered lines are abandoned, the output val drops asynchronously, and the next request starts clean.

Test Plan:
1. Meta num_blocks=2; 10 lines D0..D9 with last on D9; dst rdy=1. Required: header {ovf=0, blocks=2, count=10} at T+1, then D0..D9 with last only on D9.
2. Same as 1 with dst rdy toggled at random (50%). Required: identical sequence; val/data/last stable while rdy=0; no loss or duplication.
3. BUF_LINES=8; 11 lines with last on line 10. Required: header count=8, bit32=1; D0..D7 out, last on D7; framer_overflow=1 and stays 1 for the next request.
4. Encoder val=1 with D0 held 5 cycles before meta arrives. Required: framer_encoder_data_rdy=0 throughout; D0 accepted the cycle after the meta handshake.
5. Single line with last on it, then immediately a second request of 3 lines. Required: header count=1, D0 with last; the second meta is accepted only after that last handshake; second header count=3.
6. rst_n asserted while line 4 of 10 is draining. Required: val=0 immediately; after release, a new 2-line request produces header count=2 and correct payload with no stale lines.
